// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer between the 8-wide fetch stage and the 3-wide decode stage.
// Latency: 1 cycle. An entry written at edge N is visible on out_* after edge N (no bypass).
// Backpressure: in_ready drops when fewer than 8 slots are free; decode pulls 0..3 entries per cycle.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 redirect: empties the queue at the next edge (beats enqueue/dequeue)
//   in_count/in_instr/in_pc   fetch group, lanes 0..in_count-1 valid, lane 0 oldest (32b per lane)
//   in_ready              at least 8 free slots; fetch group is ignored while low
//   out_count/out_instr/out_pc  up to 3 oldest entries, lane 0 oldest, unused lanes zero
//   deq_count             entries consumed by decode (clamped to out_count)
//   occupancy             stored entry count
// Optional build macro FETCHQ_NOP_SQUASH_EN: drop all-zero (NOP) fetch lanes and compact the rest.

module fetch_queue #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [3:0]       in_count,
    input  logic [255:0]     in_instr,
    input  logic [255:0]     in_pc,
    output logic             in_ready,
    output logic [1:0]       out_count,
    output logic [95:0]      out_instr,
    output logic [95:0]      out_pc,
    input  logic [1:0]       deq_count,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage is not reset; occupancy alone decides which entries are live.
    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [CNT_W-1:0] free_slots;
    logic [1:0]       eff_deq;
    logic [3:0]       in_lanes;
    logic [7:0]       lane_keep;
    logic [2:0]       lane_slot [8];
    logic [3:0]       enq_num;

    // ------------------------------------------------------------------
    // Status outputs: derived from registered occupancy only, so nothing
    // on the fetch or decode side can loop back combinationally.
    // ------------------------------------------------------------------
    assign free_slots = CNT_W'(DEPTH) - occupancy;
    assign in_ready   = (free_slots >= CNT_W'(8));
    assign out_count  = (occupancy >= CNT_W'(3)) ? 2'd3 : occupancy[1:0];

    // Decode may ask for more than is shown; consume only what is shown.
    assign eff_deq = (deq_count > out_count) ? out_count : deq_count;

    // ------------------------------------------------------------------
    // Read side: lanes beyond out_count are forced to zero so decode never
    // sees stale array contents.
    // ------------------------------------------------------------------
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        for (int j = 0; j < 3; j++) begin
            if (2'(j) < out_count) begin
                out_instr[32*j +: 32] = mem_instr[head + PTR_W'(j)];
                out_pc[32*j +: 32]    = mem_pc[head + PTR_W'(j)];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write side: each kept lane gets a slot offset equal to the number of
    // kept lanes before it. Without squashing this is simply the lane index;
    // with squashing it closes the gaps left by dropped NOPs so the stored
    // stream stays contiguous and in order.
    // ------------------------------------------------------------------
    always_comb begin
        in_lanes  = (in_count > 4'd8) ? 4'd8 : in_count;
        enq_num   = '0;
        lane_keep = '0;
        for (int k = 0; k < 8; k++) begin
            lane_slot[k] = enq_num[2:0];
            if (in_ready && !flush && (4'(k) < in_lanes)) begin
`ifdef FETCHQ_NOP_SQUASH_EN
                lane_keep[k] = (in_instr[32*k +: 32] != 32'h0000_0000);
`else
                lane_keep[k] = 1'b1;
`endif
            end
            if (lane_keep[k]) begin
                enq_num = enq_num + 4'd1;
            end
        end
    end

    // Array writes: slot offsets are distinct, so lanes never collide.
    // Modulo wrap falls out of the PTR_W-bit index arithmetic.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (lane_keep[k]) begin
                mem_instr[tail + PTR_W'(lane_slot[k])] <= in_instr[32*k +: 32];
                mem_pc[tail + PTR_W'(lane_slot[k])]    <= in_pc[32*k +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy. Flush wins over simultaneous enqueue/dequeue;
    // lane_keep is already gated by flush so the array is left untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PTR_W'(eff_deq);
            tail      <= tail + PTR_W'(enq_num);
            occupancy <= occupancy + CNT_W'(enq_num) - CNT_W'(eff_deq);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic.
// Each stimulus cycle pushes the expected post-edge view from a queue-based
// reference model; a monitor pops and compares after every rising edge.

module tb_fetch_queue;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef FETCHQ_NOP_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [3:0]       in_count;
    logic [255:0]     in_instr;
    logic [255:0]     in_pc;
    logic             in_ready;
    logic [1:0]       out_count;
    logic [95:0]      out_instr;
    logic [95:0]      out_pc;
    logic [1:0]       deq_count;
    logic [CNT_W-1:0] occupancy;

    fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_count  (in_count),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_count (out_count),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .deq_count (deq_count),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] occ;
        logic [1:0]       oc;
        logic             rdy;
        logic [95:0]      ins;
        logic [95:0]      pcs;
    } exp_t;

    logic [63:0] mq[$];     // reference queue, entry = {pc, instr}
    exp_t        exp_q[$];  // scoreboard of expected post-edge views
    int          tests  = 0;
    int          failed = 0;
    logic [31:0] next_pc = 32'h0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs as a pure function of the reference queue contents.
    function automatic exp_t snap();
        exp_t e;
        int   sz;
        e     = '0;
        sz    = mq.size();
        e.occ = CNT_W'(sz);
        e.oc  = (sz < 3) ? 2'(sz) : 2'd3;
        e.rdy = ((DEPTH - sz) >= 8);
        for (int j = 0; j < 3; j++) begin
            if (j < sz) begin
                e.ins[32*j +: 32] = mq[j][31:0];
                e.pcs[32*j +: 32] = mq[j][63:32];
            end
        end
        return e;
    endfunction

    task automatic model_step(input logic f, input int cnt, input int deq,
                              input logic [255:0] ins, input logic [255:0] pcs,
                              output int accepted);
        int sz, shown, eff, n;
        sz       = mq.size();
        shown    = (sz < 3) ? sz : 3;
        eff      = (deq < shown) ? deq : shown;
        accepted = 0;
        if (f) begin
            mq.delete();
        end else begin
            if ((DEPTH - sz) >= 8) begin
                n        = (cnt > 8) ? 8 : cnt;
                accepted = n;
            end else begin
                n = 0;
            end
            repeat (eff) void'(mq.pop_front());
            for (int k = 0; k < n; k++) begin
                if (!(SQUASH && ins[32*k +: 32] == 32'h0))
                    mq.push_back({pcs[32*k +: 32], ins[32*k +: 32]});
            end
        end
    endtask

    // One stimulus cycle: drive at the falling edge, record expectation.
    task automatic drive(input logic f, input int cnt, input int deq, input logic [7:0] nop);
        logic [255:0] ins;
        logic [255:0] pcs;
        int           acc;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            pcs[32*k +: 32] = next_pc + 32'(4 * k);
            ins[32*k +: 32] = nop[k] ? 32'h0 : ($urandom | 32'h1);
        end
        flush     = f;
        in_count  = 4'(cnt);
        deq_count = 2'(deq);
        in_instr  = ins;
        in_pc     = pcs;
        model_step(f, cnt, deq, ins, pcs, acc);
        next_pc   = next_pc + 32'(4 * acc);
        exp_q.push_back(snap());
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_occ"},   96'(occupancy), 96'd0);
        check({tag, "_oc"},    96'(out_count), 96'd0);
        check({tag, "_rdy"},   96'(in_ready),  96'd1);
        check({tag, "_instr"}, out_instr,      96'd0);
        check({tag, "_pc"},    out_pc,         96'd0);
    endtask

    // Monitor: compare DUT outputs after each edge that had stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("occupancy", 96'(occupancy), 96'(e.occ));
                check("out_count", 96'(out_count), 96'(e.oc));
                check("in_ready",  96'(in_ready),  96'(e.rdy));
                check("out_instr", out_instr,      e.ins);
                check("out_pc",    out_pc,         e.pcs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_count  = '0;
        in_instr  = '0;
        in_pc     = '0;
        deq_count = '0;
        #12;
        check_empty("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill then drain: 8 in, then 3/3/2 out.
        next_pc = 32'h0;
        drive(0, 8, 0, 8'h00);
        drive(0, 0, 3, 8'h00);
        drive(0, 0, 3, 8'h00);
        drive(0, 0, 3, 8'h00);
        drive(0, 0, 0, 8'h00);

        // Full back-pressure: 16 stored, third group ignored, dequeue 3 keeps in_ready low.
        drive(0, 8, 0, 8'h00);
        drive(0, 8, 0, 8'h00);
        drive(0, 8, 0, 8'h00);
        drive(0, 0, 3, 8'h00);
        repeat (5) drive(0, 0, 3, 8'h00);

        // Continuous traffic across the wrap point.
        repeat (20) drive(0, 8, 3, 8'h00);

        // Flush priority from occupancy 10.
        drive(1, 0, 0, 8'h00);
        drive(0, 8, 0, 8'h00);
        drive(0, 2, 0, 8'h00);
        drive(1, 8, 3, 8'h00);
        drive(0, 0, 0, 8'h00);

        // Dequeue clamp at occupancy 1.
        drive(0, 1, 0, 8'h00);
        drive(0, 0, 3, 8'h00);

        // NOPs in lanes 2 and 5.
        drive(0, 8, 0, 8'b0010_0100);
        drive(0, 0, 0, 8'h00);
        drive(1, 0, 0, 8'h00);

        // in_count above 8 is treated as 8.
        drive(0, 13, 0, 8'h00);
        drive(0, 15, 2, 8'h00);
        drive(1, 0, 0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end

        // Asynchronous reset mid-cycle with 5 entries stored.
        drive(1, 0, 0, 8'h00);
        drive(0, 5, 0, 8'h00);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_empty("async_rst");
        flush     = 1'b0;
        in_count  = '0;
        deq_count = '0;
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 8'h00);
        drive(0, 3, 1, 8'h00);
        drive(0, 0, 0, 8'h00);

        @(negedge clk);
        in_count  = '0;
        deq_count = '0;
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 96'(exp_q.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
